// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [2:0] {
    MODE_B  = 3'b000,
    MODE_H  = 3'b001,
    MODE_W  = 3'b010,
    MODE_BU = 3'b100,
    MODE_HU = 3'b101
  } addr_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // True when the access mode is legal and the byte offset suits its size.
  function automatic logic is_aligned(input logic [2:0] mode, input logic [1:0] addr);
    logic ok;
    case (mode)
      MODE_B, MODE_BU: ok = 1'b1;
      MODE_H, MODE_HU: ok = !addr[0];
      MODE_W:          ok = (addr == 2'b00);
      default:         ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the pipeline memory stage and the responder.
interface dmem_responder_if #(parameter int DATA_WIDTH = 32);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_addr_mode;
  logic [DATA_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr_mode, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr_mode, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: load extraction/extension, store lane placement, access check.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    we,
  input  logic [2:0]              mode,
  input  logic [1:0]              addr,
  input  logic [DATA_WIDTH-1:0]   rawWord,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [DATA_WIDTH/8-1:0] byteEn,
  output logic [DATA_WIDTH-1:0]   wdataLanes,
  output logic                    err
);
  localparam int NUM_LANES = DATA_WIDTH / 8;

  logic [4:0]            shAmt;
  logic [DATA_WIDTH-1:0] shifted;

  assign shAmt      = {addr, 3'b000};
  assign shifted    = rawWord >> shAmt;
  assign wdataLanes = wdata << shAmt;

  // Decode legality, extend the addressed bytes, and build store lane enables.
  always_comb begin
    err    = !is_aligned(mode, addr) || (we && (mode == MODE_BU || mode == MODE_HU));
    rdata  = '0;
    byteEn = '0;
    case (mode)
      MODE_B: begin
        rdata  = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
        byteEn = NUM_LANES'(1) << addr;
      end
      MODE_H: begin
        rdata  = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
        byteEn = NUM_LANES'(3) << addr;
      end
      MODE_W: begin
        rdata  = rawWord;
        byteEn = '1;
      end
      MODE_BU: rdata = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      MODE_HU: rdata = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      default: ;
    endcase
    if (err || we) rdata  = '0;
    if (err || !we) byteEn = '0;
  end
endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency memory responder with a byte-addressable little-endian array.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDRESS_REAL_WIDTH = 12,
  parameter int LATENCY            = 2
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus
);
  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int DEPTH     = 2 ** ADDRESS_REAL_WIDTH;
  localparam int AW        = ADDRESS_REAL_WIDTH;

  typedef struct packed {
    logic                  we;
    logic [2:0]            mode;
    logic [AW-1:0]         addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  state_t                 state;
  logic [3:0]             cnt;
  req_t                   capReq, liveReq, srcReq;
  logic                   readyReg, rspValid, rspErr;
  logic [DATA_WIDTH-1:0]  rspRdata;
  logic [7:0]             mem [DEPTH];
  logic [DATA_WIDTH-1:0]  rawWord, alignRdata, wdataLanes;
  logic [NUM_LANES-1:0]   byteEn;
  logic                   alignErr;

  assign liveReq = '{we: bus.req_we, mode: bus.req_addr_mode,
                     addr: bus.req_addr[AW-1:0], wdata: bus.req_wdata};
  // With LATENCY=1 the response is formed on the accept edge, so look at live inputs in IDLE.
  assign srcReq  = (state == IDLE) ? liveReq : capReq;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign rawWord[l*8 +: 8] = mem[{srcReq.addr[AW-1:2], 2'(l)}];
  end

  dmem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .we(srcReq.we), .mode(srcReq.mode), .addr(srcReq.addr[1:0]),
    .rawWord(rawWord), .wdata(srcReq.wdata),
    .rdata(alignRdata), .byteEn(byteEn), .wdataLanes(wdataLanes), .err(alignErr)
  );

  // Request FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      capReq   <= '0;
      readyReg <= 1'b1;
      rspValid <= 1'b0;
      rspErr   <= 1'b0;
      rspRdata <= '0;
    end else begin
      rspValid <= 1'b0;
      rspErr   <= 1'b0;
      rspRdata <= '0;
      case (state)
        IDLE: if (bus.req_valid) begin
          capReq   <= liveReq;
          cnt      <= 4'(LATENCY - 1);
          readyReg <= 1'b0;
          if (LATENCY > 1) state <= WAIT;
          else begin
            state    <= RESP;
            rspValid <= 1'b1;
            rspErr   <= alignErr;
            rspRdata <= alignRdata;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state    <= RESP;
            rspValid <= 1'b1;
            rspErr   <= alignErr;
            rspRdata <= alignRdata;
          end
        end
        RESP: begin
          state    <= IDLE;
          readyReg <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Store commit on the edge that ends RESP; lane enables are already gated by we/err.
  always_ff @(posedge clk) begin
    if (state == RESP) begin
      for (int l = 0; l < NUM_LANES; l++)
        if (byteEn[l]) mem[{capReq.addr[AW-1:2], 2'(l)}] <= wdataLanes[l*8 +: 8];
    end
  end

  assign bus.req_ready = readyReg;
  assign bus.rsp_valid = rspValid;
  assign bus.rsp_err   = rspErr;
  assign bus.rsp_rdata = rspRdata;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table plus reset/handshake sequences.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 12;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_responder_if #(.DATA_WIDTH(DW)) bus ();

  dmem_responder #(.DATA_WIDTH(DW), .ADDRESS_REAL_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expData;
    logic        expErr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic addVec(input string nm, input logic we, input logic [2:0] mode,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] expData, input logic expErr);
    vec_t v;
    v.name = nm; v.we = we; v.mode = mode; v.addr = addr; v.wdata = wdata;
    v.expData = expData; v.expErr = expErr;
    vecs.push_back(v);
  endtask

  // One full transaction: accept, timing of ready/valid, response payload, return to idle.
  task automatic doReq(input vec_t v);
    int waitCnt = 0;
    while (bus.req_ready !== 1'b1 && waitCnt < 20) begin
      @(posedge clk); #1; waitCnt++;
    end
    if (bus.req_ready !== 1'b1) begin
      errors++; checks++;
      $display("FAIL %s_ready_timeout: req_ready %b after %0d cycles", v.name, bus.req_ready, waitCnt);
      return;
    end
    @(negedge clk);
    bus.req_valid     = 1'b1;
    bus.req_we        = v.we;
    bus.req_addr_mode = v.mode;
    bus.req_addr      = v.addr;
    bus.req_wdata     = v.wdata;
    @(posedge clk); #1;
    // Scramble inputs after accept; they must have no effect.
    bus.req_valid     = 1'b0;
    bus.req_we        = ~v.we;
    bus.req_addr_mode = 3'b111;
    bus.req_addr      = ~v.addr;
    bus.req_wdata     = ~v.wdata;
    for (int k = 1; k <= LAT; k++) begin
      chk({v.name, "_ready_low"}, {31'b0, bus.req_ready}, 32'd0);
      chk({v.name, "_valid_timing"}, {31'b0, bus.rsp_valid}, {31'b0, (k == LAT)});
      if (k < LAT) begin @(posedge clk); #1; end
    end
    chk({v.name, "_rdata"}, bus.rsp_rdata, v.expData);
    chk({v.name, "_err"}, {31'b0, bus.rsp_err}, {31'b0, v.expErr});
    @(posedge clk); #1;
    chk({v.name, "_valid_drop"}, {31'b0, bus.rsp_valid}, 32'd0);
    chk({v.name, "_ready_back"}, {31'b0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    vec_t v;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr_mode = 3'b000;
    bus.req_addr = '0; bus.req_wdata = '0;

    addVec("sw010",   1, MODE_W,  32'h010,  32'hDEADBEEF, 32'h0,        0);
    addVec("lw010",   0, MODE_W,  32'h010,  32'h0,        32'hDEADBEEF, 0);
    addVec("lb013",   0, MODE_B,  32'h013,  32'h0,        32'hFFFFFFDE, 0);
    addVec("lbu013",  0, MODE_BU, 32'h013,  32'h0,        32'h000000DE, 0);
    addVec("lh012",   0, MODE_H,  32'h012,  32'h0,        32'hFFFFDEAD, 0);
    addVec("lhu010",  0, MODE_HU, 32'h010,  32'h0,        32'h0000BEEF, 0);
    addVec("sb011",   1, MODE_B,  32'h011,  32'h12345677, 32'h0,        0);
    addVec("lw010b",  0, MODE_W,  32'h010,  32'h0,        32'hDEAD77EF, 0);
    addVec("lw012m",  0, MODE_W,  32'h012,  32'h0,        32'h0,        1);
    addVec("sh011m",  1, MODE_H,  32'h011,  32'h0000FFFF, 32'h0,        1);
    addVec("lw010c",  0, MODE_W,  32'h010,  32'h0,        32'hDEAD77EF, 0);
    addVec("mode011", 0, 3'b011,  32'h010,  32'h0,        32'h0,        1);
    addVec("sbu010",  1, MODE_BU, 32'h010,  32'hFFFFFFFF, 32'h0,        1);
    addVec("lw010d",  0, MODE_W,  32'h010,  32'h0,        32'hDEAD77EF, 0);
    addVec("swalias", 1, MODE_W,  32'h1FFC, 32'hA5A5A5A5, 32'h0,        0);
    addVec("lwffc",   0, MODE_W,  32'hFFC,  32'h0,        32'hA5A5A5A5, 0);
    addVec("sh014",   1, MODE_H,  32'h014,  32'h00008001, 32'h0,        0);
    addVec("lh014",   0, MODE_H,  32'h014,  32'h0,        32'hFFFF8001, 0);
    addVec("lb015",   0, MODE_B,  32'h015,  32'h0,        32'hFFFFFF80, 0);
    addVec("lbu014",  0, MODE_BU, 32'h014,  32'h0,        32'h00000001, 0);
    addVec("sw020",   1, MODE_W,  32'h020,  32'h55555555, 32'h0,        0);

    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_err",   {31'b0, bus.rsp_err}, 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) doReq(vecs[i]);

    // Reset during WAIT: no response, no write, ready immediately.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr_mode = MODE_W;
    bus.req_addr = 32'h020; bus.req_wdata = 32'h11111111;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("midrst_accepted", {31'b0, bus.req_ready}, 32'd0);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("midrst_ready_async", {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    chk("midrst_valid_in_rst", {31'b0, bus.rsp_valid}, 32'd0);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("midrst_ready_release", {31'b0, bus.req_ready}, 32'd1);
    for (int k = 0; k < LAT + 2; k++) begin
      @(posedge clk); #1;
      chk("midrst_no_rsp", {31'b0, bus.rsp_valid}, 32'd0);
    end
    v.name = "lw020_after_rst"; v.we = 0; v.mode = MODE_W; v.addr = 32'h020;
    v.wdata = 0; v.expData = 32'h55555555; v.expErr = 0;
    doReq(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end
endmodule
